ram_sync: RTL and testbench
===========================

# ram_sync

Synchronous, parametrised single-port RAM that replaces the asynchronous 128 × 32 bidirectional-bus data memory. Separate write/read data paths, byte-lane write enables, a valid/ready request/response handshake and a programmable number of wait states emulating slow memory. Sits between the processor's memory stage and data storage. The handshake lets the pipeline stall on memory.

## Interface
- `DATA_W`, default 32: word width in bits. Must be a multiple of 8.
- `ADDR_W`, default 7: word-address width.
- `DEPTH`, default 128: number of words. Must be ≤ 2^ADDR_W.
- `WAIT_CYCLES`, default 0: extra cycles between request acceptance and the memory access. Range 0..15.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: word address.
- `req_wdata`  in  DATA_W: write data.
- `req_be`  in  DATA_W/8: byte-lane enables. Bit i covers bits [8i+7:8i]. Ignored on reads.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  DATA_W: read data, or the post-write word for writes.

## Operation
- States:
  - CLEAR: only when the macro is defined.
  - IDLE
  - WAIT
  - RESP
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `we`/`addr`/`wdata`/`be`.
  - If WAIT_CYCLES=0, go to RESP and perform the access on the same edge.
  - Otherwise load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1, perform the access and go to RESP.
- Access:
  - Read: `rsp_rdata` ← mem[addr].
  - Write: mem[addr] bytes with `be`=1 ← `wdata` bytes; the other bytes are unchanged. `rsp_rdata` ← the merged new word.
- RESP:
  - `rsp_valid`=1 and `rsp_rdata` are held stable until `rsp_ready`=1.
  - On that edge, clear `rsp_valid` and go to IDLE.
- `req_ready`=0 in every state except IDLE. There is no request accepted while a response is pending.
- Boundary conditions:
  - Address ≥ DEPTH: a write changes nothing, a read returns 0. A response is still issued.
  - Write with `req_be`=0: memory is unchanged and the response returns the current word.
  - Inputs changing while `req_ready`=0 are ignored.
- Reset:
  - `rst_n` low at an edge aborts any transaction.
  - A write still in WAIT is never committed. A write whose commit edge coincides with `rst_n` low is suppressed.
  - Memory contents are otherwise preserved across reset.

## Timing
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=0 while `rst_n`=0.
- Request accepted at edge T → `rsp_valid` high from T+1+WAIT_CYCLES.
- Throughput with `rsp_ready` held high: one transaction every 2+WAIT_CYCLES cycles.
- `req_ready` and `rsp_valid` are decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- `RAM_ZERO_INIT_EN` defined:
  - The first edge with `rst_n` high enters CLEAR.
  - A sweep counter writes 0 to addresses 0..DEPTH-1, one per cycle.
  - `req_ready`=0 throughout; then go to IDLE. The first `req_ready`=1 comes DEPTH cycles after reset release.
  - Reset during CLEAR restarts the sweep at address 0.
- `RAM_ZERO_INIT_EN` undefined:
  - Reset goes directly to IDLE, and `req_ready`=1 on the first cycle after release.
  - Contents are uninitialised (X in simulation) until written.

## Structure
- Package `ram_pkg` holds:
  - the state enum (`ST_CLEAR`, `ST_IDLE`, `ST_WAIT`, `ST_RESP`)
  - the `BE_W = DATA_W/8` derivation
  - the wait-counter width constant (4 bits).
- Sub-module `ram_array` holds the storage: one clocked port with `en`, `we`, `be`, `addr`, `wdata` and a registered `rdata`.
- `ram_sync` holds the FSM, the wait counter, the clear-sweep counter, the request latch and the out-of-range check.

## Test plan
- Write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 → `rsp_rdata`=0xDEADBEEF. Latency 1 cycle at WAIT_CYCLES=0.
- Write 0xAABBCCDD with be=4'b0101 over 0x11223344 at addr 9 → write response 0x11BB33DD, and a later read returns the same value.
- WAIT_CYCLES=3: request at edge T → `rsp_valid` at T+4. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0.
- DEPTH=100, ADDR_W=7: write 0x1 to addr 120 then read addr 120 → response 0. A read of addr 99 is unaffected.
- WAIT_CYCLES=2: write issued, `rst_n` pulsed low in WAIT → after reset, a read of that address returns the old value, `rsp_valid`=0 in reset.
- With `RAM_ZERO_INIT_EN`: release reset → `req_ready` stays 0 for 128 cycles, then a read of addr 127 returns 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared state encoding and sizing constants for the synchronous data RAM.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int CNT_W = 4;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array: one clocked port with byte-lane writes and a registered read word.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // A write returns the merged word it stores, so the response reflects the new contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= merged;
            end
            rdata <= we ? merged : mem[addr];
        end
    end

endmodule

// File: rtl/ram_sync.sv
// Synchronous single-port data RAM with valid/ready handshake and programmable wait states.
// Define RAM_ZERO_INIT_EN to sweep the array to zero after every reset before accepting requests.
module ram_sync
    import ram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata
);

    localparam int               BE_W      = be_width(DATA_W);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
`ifdef RAM_ZERO_INIT_EN
    localparam state_t           RST_ST    = ST_CLEAR;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`else
    localparam state_t           RST_ST    = ST_IDLE;
`endif

    state_t            state, state_nx;
    logic              live;
    logic [CNT_W-1:0]  cnt;
    logic              oor;
    logic              accept, access;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              in_range;

    logic              mem_en, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

`ifdef RAM_ZERO_INIT_EN
    logic [ADDR_W-1:0] sweep;
`endif

    // live is a registered copy of rst_n so req_ready stays low through reset without an input path.
    assign req_ready = live && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = (state == ST_RESP && !oor) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RST_ST;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        access   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access   = 1'b1;
                        state_nx = ST_RESP;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    access   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CLEAR: begin
`ifdef RAM_ZERO_INIT_EN
                if (sweep == LAST_ADDR) begin
                    state_nx = ST_IDLE;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            default: state_nx = RST_ST;
        endcase
    end

    // With no wait states the access happens on the accept edge, straight from the request bus.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
    end

    assign in_range = 32'(acc_addr) < 32'(DEPTH);

    // rst_n gates the enable so a commit edge that coincides with reset never writes.
    always_comb begin
        mem_en    = rst_n && access && in_range;
        mem_we    = acc_we;
        mem_be    = acc_be;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
`ifdef RAM_ZERO_INIT_EN
        if (state == ST_CLEAR) begin
            mem_en    = rst_n;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = sweep;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live <= 1'b0;
            cnt  <= '0;
            oor  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                cnt <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                oor <= !in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

`ifdef RAM_ZERO_INIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep <= '0;
        end else if (state == ST_CLEAR) begin
            sweep <= sweep + ADDR_W'(1);
        end
    end
`endif

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ram_sync.sv
// Scoreboard bench for ram_sync: random and directed requests against a word-array reference model.
`timescale 1ns/1ps
module tb_ram_sync;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 7;
    localparam int DEPTH       = 100;
    localparam int WAIT_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;

    always #5 clk = ~clk;

    ram_sync #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
    );

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm [0:DEPTH-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          in_rsp = 1'b0;
    bit          stall_next = 1'b0;
    int          hold_left = 0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour: out-of-range touches nothing and reads zero; enabled bytes replace old ones.
    function automatic logic [31:0] model_access(input logic we, input logic [6:0] a,
                                                 input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (int'(a) >= DEPTH) return 32'h0;
        w = mm[a];
        if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
            mm[a] = w;
        end
        return w;
    endfunction

    task automatic issue(input logic we, input logic [6:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit track);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 400), 32'd1);
        if (n < 400) begin
            if (track) begin
                e.data = model_access(we, a, d, be);
                e.acc  = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 7'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid || in_rsp) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
`ifdef RAM_ZERO_INIT_EN
        for (int i = 1; i < DEPTH; i++) begin
            chk("clear_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("clear_done_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
`else
        chk("first_req_ready", 32'(req_ready), 32'd1);
`endif
    endtask

    // Write accepted, then reset lands either mid-wait or exactly on the commit edge.
    task automatic abort_write(input logic [6:0] a, input bit late);
        drain();
        issue(1'b1, a, ~mm[a], 4'hF, 1'b0);
        if (late) @(negedge clk);
        do_reset(2);
        issue(1'b0, a, 32'h0, 4'h0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_rsp    = 1'b0;
            hold_left = 0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got %h with empty scoreboard", rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("latency", 32'(cyc - e.acc), 32'(WAIT_CYCLES));
                end
                held      = rsp_rdata;
                in_rsp    = 1'b1;
                hold_left = stall_next ? 5 : 0;
                stall_next = 1'b0;
            end else begin
                chk("rsp_hold_data", rsp_rdata, held);
                chk("busy_req_ready", 32'(req_ready), 32'd0);
            end
            if (hold_left > 0) begin
                rsp_ready = 1'b0;
                hold_left--;
            end else begin
                rsp_ready = ($urandom_range(0, 9) < 6);
            end
            if (rsp_ready) in_rsp = 1'b0;
        end else begin
            rsp_ready = 1'($urandom);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        for (int a = 0; a < DEPTH; a++) issue(1'b1, 7'(a), $urandom, 4'hF, 1'b1);

        issue(1'b1, 7'd5, 32'hDEADBEEF, 4'hF, 1'b1);
        issue(1'b0, 7'd5, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 7'd9, 32'h11223344, 4'hF, 1'b1);
        issue(1'b1, 7'd9, 32'hAABBCCDD, 4'b0101, 1'b1);
        issue(1'b0, 7'd9, 32'h0, 4'h0, 1'b1);

        stall_next = 1'b1;
        issue(1'b0, 7'd5, 32'h0, 4'h0, 1'b1);

        issue(1'b1, 7'd120, 32'h1, 4'hF, 1'b1);
        issue(1'b0, 7'd120, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 7'd99, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 7'd7, 32'hCAFEF00D, 4'h0, 1'b1);
        issue(1'b0, 7'd7, 32'h0, 4'h0, 1'b1);

        abort_write(7'd5, 1'b0);
        abort_write(7'd9, 1'b1);

        for (int i = 0; i < 250; i++) begin
            if (i % 40 == 0) stall_next = 1'b1;
            issue(1'($urandom), 7'($urandom_range(0, 127)), $urandom, 4'($urandom), 1'b1);
        end

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
